// File: rtl/seletor_canais_reg.sv
// seletor_canais_reg: registered N_CH-to-1 channel selector with valid/ready handshakes,
// direct-select (MODE=0) or round-robin (MODE=1) grant.
module seletor_canais_reg #(
  parameter int N_CH  = 3,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int SW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW-1:0]         SEL,
  input  logic [N_CH*WIDTH-1:0] IN_DATA,
  input  logic [N_CH-1:0]       IN_VALID,
  output logic [N_CH-1:0]       IN_READY,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic                  OUT_VALID,
  output logic [SW-1:0]         OUT_CH,
  input  logic                  OUT_READY
);
  logic [WIDTH-1:0] data_q, data_d, data_g;
  logic             valid_q, valid_d, load_en, xfer;
  logic [SW-1:0]    ch_q, ch_d, last_q, last_d, grant;
  int               best_d, d;
  // Round-robin picks the valid channel at the smallest distance after last_q.
  always_comb begin
    grant = '0;
    best_d = N_CH;
    d = 0;
    for (int j = 1; j <= N_CH; j++) begin
      if (MODE == 0) begin
        if (SEL == SW'(j) && IN_VALID[j-1]) grant = SEL;
      end else begin
        d = (j + N_CH - 1 - int'(last_q)) % N_CH;
        if (IN_VALID[j-1] && d < best_d) begin
          best_d = d;
          grant = SW'(j);
        end
      end
    end
  end
  always_comb begin
    load_en = !valid_q || OUT_READY;
    xfer = load_en && grant != '0;
    data_g = '0;
    for (int j = 1; j <= N_CH; j++) begin
      IN_READY[j-1] = rst_n && load_en && grant == SW'(j);
      if (grant == SW'(j)) data_g = IN_DATA[(j-1)*WIDTH +: WIDTH];
    end
  end
  always_comb begin
    data_d = data_q;
    valid_d = valid_q;
    ch_d = ch_q;
    last_d = last_q;
    if (xfer) begin
      data_d = data_g;
      valid_d = 1'b1;
      ch_d = grant;
      last_d = (MODE == 1) ? grant : last_q;
    end else if (OUT_READY) begin
      valid_d = 1'b0;
      ch_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      valid_q <= 1'b0;
      ch_q <= '0;
      last_q <= SW'(N_CH);
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      ch_q <= ch_d;
      last_q <= last_d;
    end
  end
  assign OUT_DATA = data_q;
  assign OUT_VALID = valid_q;
  assign OUT_CH = ch_q;
endmodule

// File: tb/tb_seletor_canais_reg.sv
// tb_seletor_canais_reg: directed plus random stimulus on a MODE=0 and a MODE=1 instance,
// checked against a cycle-level behavioural model.
module tb_seletor_canais_reg;
  localparam int N = 3, W = 8, S = 4;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
  logic [S-1:0] sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] rdy0, rdy1;
  logic [W-1:0] od0, od1;
  logic ov0, ov1;
  logic [S-1:0] oc0, oc1;
  int vectors = 0, miscompares = 0;
  int m_valid[2], m_data[2], m_ch[2], m_last;

  seletor_canais_reg #(.N_CH(N), .WIDTH(W), .MODE(0), .SW(S)) u0 (
    .clk(clk), .rst_n(rst_n), .SEL(sel), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(rdy0), .OUT_DATA(od0), .OUT_VALID(ov0), .OUT_CH(oc0), .OUT_READY(out_ready));
  seletor_canais_reg #(.N_CH(N), .WIDTH(W), .MODE(1), .SW(S)) u1 (
    .clk(clk), .rst_n(rst_n), .SEL(sel), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(rdy1), .OUT_DATA(od1), .OUT_VALID(ov1), .OUT_CH(oc1), .OUT_READY(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int grant_of(int mode);
    int c;
    if (mode == 0) begin
      c = int'(sel);
      return (c >= 1 && c <= N && in_valid[c-1]) ? c : 0;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k - 1) % N + 1;
      if (in_valid[c-1]) return c;
    end
    return 0;
  endfunction

  task automatic check_out();
    chk("out_valid0", ov0, m_valid[0]);
    chk("out_data0", od0, m_data[0]);
    chk("out_ch0", oc0, m_ch[0]);
    chk("out_valid1", ov1, m_valid[1]);
    chk("out_data1", od1, m_data[1]);
    chk("out_ch1", oc1, m_ch[1]);
  endtask

  // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
  task automatic step();
    int g[2];
    bit le[2];
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      g[m] = grant_of(m);
      le[m] = !m_valid[m] || out_ready;
    end
    chk("in_ready0", rdy0, (le[0] && g[0] != 0) ? (1 << (g[0] - 1)) : 0);
    chk("in_ready1", rdy1, (le[1] && g[1] != 0) ? (1 << (g[1] - 1)) : 0);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (le[m] && g[m] != 0) begin
        m_valid[m] = 1;
        m_data[m] = int'(in_data[(g[m]-1)*W +: W]);
        m_ch[m] = g[m];
        if (m == 1) m_last = g[m];
      end else if (out_ready) begin
        m_valid[m] = 0;
        m_ch[m] = 0;
      end
    end
    check_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0;
      m_data[m] = 0;
      m_ch[m] = 0;
    end
    m_last = N;
    check_out();
    chk("rst_in_ready0", rdy0, 0);
    chk("rst_in_ready1", rdy1, 0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 3'b111;
    sel = 4'd2;
    out_ready = 1'b1;
    do_reset();
    repeat (5) step();
    in_data = {8'h33, 8'h22, 8'h11};
    sel = 4'd2;
    in_valid = 3'b111;
    step();
    chk("dir_data", od0, 8'h22);
    chk("dir_ch", oc0, 2);
    sel = 4'd0;
    step();
    chk("sel0_valid", ov0, 0);
    chk("sel0_ch", oc0, 0);
    sel = 4'd3;
    in_valid = 3'b011;
    step();
    chk("inv_valid", ov0, 0);
    in_valid = 3'b111;
    step();
    chk("sel3_data", od0, 8'h33);
    chk("sel3_ch", oc0, 3);
    do_reset();
    in_valid = 3'b111;
    sel = 4'd0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_seq", oc1, k % 3 + 1);
    end
    in_valid = 3'b010;
    repeat (3) begin
      step();
      chk("rr_only2", oc1, 2);
    end
    sel = 4'd1;
    in_valid = 3'b001;
    step();
    out_ready = 1'b0;
    in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      sel = (k % 2 == 0) ? 4'd2 : 4'd3;
      step();
      chk("stall_data", od0, 8'h11);
      chk("stall_ch", oc0, 1);
    end
    sel = 4'd2;
    in_valid = 3'b010;
    out_ready = 1'b1;
    step();
    chk("unstall_data", od0, 8'h22);
    chk("unstall_ch", oc0, 2);
    in_valid = 3'b111;
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", ov1, 1);
    do_reset();
    chk("async_rst_valid", ov1, 0);
    in_valid = 3'b111;
    out_ready = 1'b1;
    step();
    chk("post_rst_ch", oc1, 1);
    repeat (300) begin
      in_valid = N'($urandom);
      in_data = (N*W)'($urandom);
      sel = S'($urandom_range(0, 5));
      out_ready = ($urandom % 4) != 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
